dwt_level_sequencer: RTL and testbench
======================================

// Module: dwt_level_sequencer
// PURPOSE
//  Frame-based multi-level 1D integer Haar (S-transform) DWT engine. Accepts N samples
//  over a valid/ready stream and buffers them. Drives one shared lifting unit (one pair
//  per cycle) through L decomposition levels, then streams the N coefficients out in
//  Mallat order. Sits between the sample source and downstream coefficient consumers.
// PARAMETERS
//  N  8  samples per frame; power of 2, >=2
//  L  3  decomposition levels; 1 <= L <= log2(N)
//  W  8  input sample width, signed two's complement
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      asynchronous, active-high; clears all state
//  in_valid    in   1      in_data valid
//  in_ready    out  1      block accepts a sample this cycle
//  in_data     in   W      signed input sample
//  out_valid   out  1      out_data valid
//  out_ready   in   1      consumer accepts out_data this cycle
//  out_data    out  W+L    signed coefficient, sign-extended
//  busy        out  1      high in COMPUTE, COMMIT and OUTPUT
//  level       out  clog2(L+1)  level being computed (1..L); 0 outside COMPUTE/COMMIT
//  frame_done  out  1      one-cycle pulse on the cycle of the last output handshake
// BEHAVIOUR
//  Reset values: in_ready=0 while reset asserted, then 1 (LOAD); out_valid=0, out_data=0,
//   busy=0, level=0, frame_done=0; buffer, counters and FSM cleared; partial frame dropped.
//  Internal: buf[0..N-1] and shadow[0..N-1], each W+L bits signed; len, pair idx j, out idx.
//  FSM: LOAD -> COMPUTE -> COMMIT -> (COMPUTE | OUTPUT) -> LOAD.
//  LOAD: in_ready=1; on in_valid&&in_ready, buf[cnt]<=sext(in_data), cnt++. After the
//   N-th accept -> COMPUTE with level=1, len=N, j=0. No bubbles between accepted samples.
//  COMPUTE: per cycle a=buf[2j], b=buf[2j+1]; d=a-b; s=b+(d>>>1) (arithmetic shift,
//   = floor((a+b)/2)). shadow[j]<=s, shadow[len/2+j]<=d. j=len/2-1 -> COMMIT.
//  COMMIT (1 cycle): buf[0..len-1]<=shadow[0..len-1]; buf[len..N-1] unchanged.
//   If level<L: level++, len>>=1, j=0 -> COMPUTE. Else -> OUTPUT, out idx=0.
//  Compute time = sum over k=1..L of (N>>k)+1 cycles (N=8, L=3: 10 cycles).
//  OUTPUT: out_valid=1, out_data=buf[idx]; on out_valid&&out_ready idx++. out_data holds
//   stable while out_valid&&!out_ready. Last handshake: frame_done=1, -> LOAD next cycle.
//   Order: [s_L block, d_L, d_(L-1), ..., d_1] (N=8,L=3: a3, d3, d2 x2, d1 x4).
//  in_ready=0 in COMPUTE/COMMIT/OUTPUT; in_valid ignored there (no accept, no drop count).
//  Width: d at level k fits W+k bits; s stays within W-bit range; no saturation/overflow
//   at W+L. All arithmetic signed.
//  Reset mid-frame (any state): async return to LOAD on deassert; no output of old frame.
//  Latency, last input accept -> first out_valid: compute time + 1 cycle.
// TESTING
//  1) in=1,2,..,8 (N=8,L=3,W=8), out_ready=1 -> out 4,-4,-2,-2,-1,-1,-1,-1; frame_done on 8th.
//  2) in=-128,127 alternating x4 -> out -1,0,0,0,-255,-255,-255,-255 (no overflow, 11b).
//  3) constant 5 x8 -> out 5,0,0,0,0,0,0,0; first out_valid 11 cycles after last accept.
//  4) out_ready toggled 1/0 each cycle, in_valid held high during OUTPUT -> same data as (1),
//     out_data stable on stalls, in_ready=0 until cycle after frame_done, no extra accepts.
//  5) assert reset after 5 of 8 samples, then send a full frame 1..8 -> output exactly (1).
//  6) L=1 build, in=1..8 -> out 1,3,5,7,-1,-1,-1,-1; two frames back-to-back, both correct.

Source files
------------

// File: rtl/dwt_level_sequencer.sv
// Multi-level 1D integer Haar (S-transform) DWT engine: buffers a frame of N samples,
// runs L lifting levels through one shared pair unit, then streams coefficients in Mallat order.
module dwt_level_sequencer #(
  parameter int N = 8,
  parameter int L = 3,
  parameter int W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W+L-1:0]   out_data_o,
  output logic             busy_o,
  output logic [$clog2(L+1)-1:0] level_o,
  output logic             frame_done_o
);

  localparam int CW = W + L;
  localparam int IW = $clog2(N);
  localparam int LW = $clog2(L + 1);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    COMMIT  = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       j_q, j_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [IW:0]         len_q, len_d;
  logic [LW-1:0]       level_q, level_d;

  logic signed [CW-1:0] buf_q    [N];
  logic signed [CW-1:0] shadow_q [N];

  logic [IW:0]          half;
  logic [IW-1:0]        ia, ib, hi;
  logic signed [CW-1:0] a_val, b_val, d_diff, s_sum;

  assign half   = len_q >> 1;
  assign ia     = IW'({j_q, 1'b0});
  assign ib     = ia | IW'(1);
  assign hi     = IW'(half) + j_q;
  assign a_val  = buf_q[ia];
  assign b_val  = buf_q[ib];
  assign d_diff = a_val - b_val;
  // s = b + floor(d/2) == floor((a+b)/2) without needing an extra bit for a+b
  assign s_sum  = b_val + (d_diff >>> 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    j_d     = j_q;
    idx_d   = idx_q;
    len_d   = len_q;
    level_d = level_q;
    unique case (state_q)
      LOAD: begin
        if (in_valid_i) begin
          cnt_d = cnt_q + IW'(1);
          if (cnt_q == IW'(N - 1)) begin
            state_d = COMPUTE;
            cnt_d   = '0;
            level_d = LW'(1);
            len_d   = (IW+1)'(N);
            j_d     = '0;
          end
        end
      end
      COMPUTE: begin
        j_d = j_q + IW'(1);
        if ({1'b0, j_q} == half - (IW+1)'(1)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (level_q < LW'(L)) begin
          state_d = COMPUTE;
          level_d = level_q + LW'(1);
          len_d   = half;
          j_d     = '0;
        end else begin
          state_d = OUTPUT;
          level_d = '0;
          idx_d   = '0;
        end
      end
      OUTPUT: begin
        if (out_ready_i) begin
          idx_d = idx_q + IW'(1);
          if (idx_q == IW'(N - 1)) begin
            state_d = LOAD;
            idx_d   = '0;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      j_q     <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      level_q <= '0;
      for (int i = 0; i < N; i++) begin
        buf_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      level_q <= level_d;
      if (state_q == LOAD && in_valid_i) begin
        buf_q[cnt_q] <= {{L{in_data_i[W-1]}}, in_data_i};
      end
      if (state_q == COMPUTE) begin
        shadow_q[j_q] <= s_sum;
        shadow_q[hi]  <= d_diff;
      end
      // Only the active prefix is replaced; finer-level details above len stay put
      if (state_q == COMMIT) begin
        for (int i = 0; i < N; i++) begin
          if (i < int'(len_q)) buf_q[i] <= shadow_q[i];
        end
      end
    end
  end

  assign in_ready_o   = (state_q == LOAD) && !reset_i;
  assign out_valid_o  = (state_q == OUTPUT);
  assign out_data_o   = (state_q == OUTPUT) ? buf_q[idx_q] : '0;
  assign busy_o       = (state_q != LOAD);
  assign level_o      = level_q;
  assign frame_done_o = (state_q == OUTPUT) && out_ready_i && (idx_q == IW'(N - 1));

endmodule

// File: tb/tb_dwt_level_sequencer.sv
// Bench for dwt_level_sequencer: an L=3 and an L=1 instance checked every cycle against a
// list-based Haar model, plus literal expectations for the directed frames.
module tb_dwt_level_sequencer;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int LA = 3;
  localparam int LB = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] in_data;
  logic in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a, frame_done_a;
  logic in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b, frame_done_b;
  logic [W+LA-1:0] out_data_a;
  logic [W+LB-1:0] out_data_b;
  logic [$clog2(LA+1)-1:0] level_a;
  logic [$clog2(LB+1)-1:0] level_b;

  dwt_level_sequencer #(.N(N), .L(LA), .W(W)) dut_a (
    .clk_i(clk), .reset_i(reset),
    .in_valid_i(in_valid_a), .in_ready_o(in_ready_a), .in_data_i(in_data),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready_a), .out_data_o(out_data_a),
    .busy_o(busy_a), .level_o(level_a), .frame_done_o(frame_done_a)
  );

  dwt_level_sequencer #(.N(N), .L(LB), .W(W)) dut_b (
    .clk_i(clk), .reset_i(reset),
    .in_valid_i(in_valid_b), .in_ready_o(in_ready_b), .in_data_i(in_data),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready_b), .out_data_o(out_data_b),
    .busy_o(busy_b), .level_o(level_b), .frame_done_o(frame_done_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Haar S-transform on plain lists: split into floor averages and differences, recurse on averages
  function automatic void dwt_model(input int x[N], input int lv, output int y[N]);
    int appr[$];
    int det[$];
    int s[$];
    int d[$];
    int k;
    for (int i = 0; i < N; i++) appr.push_back(x[i]);
    for (int lvl = 1; lvl <= lv; lvl++) begin
      s = {};
      d = {};
      for (int p = 0; p < appr.size(); p += 2) begin
        d.push_back(appr[p] - appr[p+1]);
        s.push_back((appr[p] + appr[p+1]) >>> 1);
      end
      det  = {d, det};
      appr = s;
    end
    k = 0;
    foreach (appr[i]) begin y[k] = appr[i]; k++; end
    foreach (det[i])  begin y[k] = det[i];  k++; end
  endfunction

  function automatic int ctime(input int lv);
    int t = 0;
    for (int k = 1; k <= lv; k++) t += (N >> k) + 1;
    return t;
  endfunction

  function automatic int exp_level(input int lv, input int c);
    int r = c;
    for (int k = 1; k <= lv; k++) begin
      if (r < (N >> k) + 1) return k;
      r -= (N >> k) + 1;
    end
    return 0;
  endfunction

  int  acc_v [2][N];
  int  acc_n [2];
  int  exp_v [2][N];
  int  got   [2][N];
  int  out_i [2];
  int  since [2];
  bit  pend  [2];
  int  total_acc  [2];
  int  frames_out [2];
  bit  stall_prev [2];
  int  stall_val  [2];

  task automatic observe(input int u, input int lv, input bit iv, input bit ir, input bit ov,
                         input bit orr, input bit bz, input bit fd, input int dat,
                         input int lvl, input int od);
    bit ove;
    bit hs;
    int fr[N];
    int y[N];
    if (reset) begin
      chk("rst_in_ready", int'(ir), 0);
      chk("rst_out_valid", int'(ov), 0);
      chk("rst_busy", int'(bz), 0);
      chk("rst_frame_done", int'(fd), 0);
      chk("rst_level", lvl, 0);
      chk("rst_out_data", od, 0);
      acc_n[u] = 0; pend[u] = 0; out_i[u] = 0; since[u] = 0; stall_prev[u] = 0;
      return;
    end
    ove = pend[u] && since[u] >= ctime(lv);
    hs  = ove && orr;
    chk("in_ready", int'(ir), int'(!pend[u]));
    chk("busy", int'(bz), int'(pend[u]));
    chk("level", lvl, (pend[u] && !ove) ? exp_level(lv, since[u]) : 0);
    chk("out_valid", int'(ov), int'(ove));
    chk("frame_done", int'(fd), int'(hs && out_i[u] == N - 1));
    if (ove) chk($sformatf("out_data[%0d]", out_i[u]), od, exp_v[u][out_i[u]]);
    if (stall_prev[u] && ove) chk("stall_stable", od, stall_val[u]);
    stall_prev[u] = ove && !orr;
    stall_val[u]  = od;
    if (pend[u]) since[u]++;
    if (hs) begin
      got[u][out_i[u]] = od;
      out_i[u]++;
      if (out_i[u] == N) begin
        out_i[u] = 0;
        pend[u]  = 0;
        frames_out[u]++;
      end
    end
    if (iv && !pend[u] && !hs) begin
      acc_v[u][acc_n[u]] = dat;
      acc_n[u]++;
      total_acc[u]++;
      if (acc_n[u] == N) begin
        for (int i = 0; i < N; i++) fr[i] = acc_v[u][i];
        dwt_model(fr, lv, y);
        for (int i = 0; i < N; i++) exp_v[u][i] = y[i];
        acc_n[u] = 0;
        pend[u]  = 1;
        since[u] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    observe(0, LA, in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a, frame_done_a,
            int'($signed(in_data)), int'(level_a), int'($signed(out_data_a)));
    observe(1, LB, in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b, frame_done_b,
            int'($signed(in_data)), int'(level_b), int'($signed(out_data_b)));
  end

  function automatic bit rdy(input int u);
    return (u == 0) ? in_ready_a : in_ready_b;
  endfunction

  task automatic set_valid(input int u, input bit v);
    if (u == 0) in_valid_a = v; else in_valid_b = v;
  endtask

  task automatic set_ordy(input int u, input bit v);
    if (u == 0) out_ready_a = v; else out_ready_b = v;
  endtask

  task automatic send(input int u, input int v[N], input int nsend, input bit hold_valid);
    int g;
    for (int i = 0; i < nsend; i++) begin
      in_data = W'(v[i]);
      set_valid(u, 1'b1);
      g = 0;
      @(negedge clk);
      while (!rdy(u) && g < 100) begin
        @(negedge clk);
        g++;
      end
      chk("in_ready_wait", int'(rdy(u)), 1);
      @(posedge clk);
      #1;
    end
    if (!hold_valid) set_valid(u, 1'b0);
  endtask

  task automatic drain(input int u, input bit toggle);
    int f0;
    int g;
    f0 = frames_out[u];
    g = 0;
    set_ordy(u, 1'b1);
    while (frames_out[u] == f0 && g < 200) begin
      @(posedge clk);
      #1;
      g++;
      if (toggle) set_ordy(u, g[0]);
    end
    set_valid(u, 1'b0);
    set_ordy(u, 1'b1);
    chk("frame_completed", frames_out[u] - f0, 1);
  endtask

  task automatic lit(input int u, input string tag, input int e[N]);
    for (int i = 0; i < N; i++) chk($sformatf("%s[%0d]", tag, i), got[u][i], e[i]);
  endtask

  initial begin
    int f_ramp[N];
    int f_alt[N];
    int f_const[N];
    int e_ramp3[N];
    int e_alt3[N];
    int e_const3[N];
    int e_ramp1[N];
    int y[N];
    int n;
    int acc0;

    f_ramp   = '{1, 2, 3, 4, 5, 6, 7, 8};
    f_alt    = '{-128, 127, -128, 127, -128, 127, -128, 127};
    f_const  = '{5, 5, 5, 5, 5, 5, 5, 5};
    e_ramp3  = '{4, -4, -2, -2, -1, -1, -1, -1};
    e_alt3   = '{-1, 0, 0, 0, -255, -255, -255, -255};
    e_const3 = '{5, 0, 0, 0, 0, 0, 0, 0};
    e_ramp1  = '{1, 3, 5, 7, -1, -1, -1, -1};

    in_data = '0;
    in_valid_a = 0; in_valid_b = 0;
    out_ready_a = 1; out_ready_b = 1;
    for (int u = 0; u < 2; u++) begin
      acc_n[u] = 0; out_i[u] = 0; since[u] = 0; pend[u] = 0;
      total_acc[u] = 0; frames_out[u] = 0; stall_prev[u] = 0; stall_val[u] = 0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 0;

    dwt_model(f_ramp, LA, y);
    for (int i = 0; i < N; i++) chk($sformatf("model_ramp3[%0d]", i), y[i], e_ramp3[i]);
    dwt_model(f_alt, LA, y);
    for (int i = 0; i < N; i++) chk($sformatf("model_alt3[%0d]", i), y[i], e_alt3[i]);
    dwt_model(f_ramp, LB, y);
    for (int i = 0; i < N; i++) chk($sformatf("model_ramp1[%0d]", i), y[i], e_ramp1[i]);
    chk("model_ctime", ctime(LA), 10);

    send(0, f_ramp, N, 0);
    drain(0, 0);
    lit(0, "ramp", e_ramp3);

    send(0, f_alt, N, 0);
    drain(0, 0);
    lit(0, "alt", e_alt3);

    send(0, f_const, N, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid_a && n < 50);
    chk("latency", n, 11);
    drain(0, 0);
    lit(0, "const", e_const3);

    acc0 = total_acc[0];
    send(0, f_ramp, N, 1);
    drain(0, 1);
    lit(0, "stall", e_ramp3);
    chk("stall_accepts", total_acc[0] - acc0, N);

    send(0, f_ramp, 5, 0);
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    send(0, f_ramp, N, 0);
    drain(0, 0);
    lit(0, "after_rst", e_ramp3);

    send(1, f_ramp, N, 0);
    drain(1, 0);
    lit(1, "l1_first", e_ramp1);
    send(1, f_ramp, N, 0);
    drain(1, 0);
    lit(1, "l1_second", e_ramp1);
    chk("l1_frames", frames_out[1], 2);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
